alu_seq_exec: RTL and testbench
===============================

// Module: alu_seq_exec
// PURPOSE
//  Execute-stage ALU that consumes the 4-bit ALU control code from the ALU control decoder.
//  AND/OR/ADD/SUB/SLL/SRL/SLT complete in one cycle. MUL runs as an iterative shift-add sequence.
//  A start/busy/valid handshake lets the pipeline controller stall the EX stage while MUL is running.
// PARAMETERS
//  DATA_W    64  operand and result width; power of two, >= 8
//  MUL_STEP  1   multiplier bits retired per MUL cycle; must divide DATA_W; ITERS = DATA_W/MUL_STEP
// PORTS
//  clk          in   1       rising-edge clock
//  arst_n       in   1       reset, synchronous, active-low
//  start        in   1       request; sampled only while idle (busy=0)
//  alu_control  in   4       op: AND=0 OR=1 ADD=2 SLL=3 SRL=4 SUB=6 SLT=7 MUL=8
//  operand_a    in   DATA_W  first operand (rs1)
//  operand_b    in   DATA_W  second operand (rs2 or immediate)
//  result       out  DATA_W  registered result; holds until the next valid
//  zero         out  1       registered (result == 0); updates together with result
//  busy         out  1       high while a MUL is in progress
//  valid        out  1       one-cycle pulse: result/zero are new this cycle
// BEHAVIOUR
//  - Reset (arst_n=0 at a clk edge): state=IDLE; result=0, zero=1, busy=0, valid=0. Any MUL in flight is discarded.
//  - FSM states: IDLE, MUL_RUN.
//    IDLE & start & code!=MUL: result <= f(a,b); valid <= 1; stay in IDLE.
//    IDLE & start & code==MUL: latch a, b; acc <= 0; cnt <= ITERS; go to MUL_RUN; valid <= 0.
//    MUL_RUN: each edge: acc += (b_lsbs * a_shifted); shift; cnt--.
//      When cnt==1, write acc[DATA_W-1:0] to result, set valid <= 1, return to IDLE.
//    Otherwise valid <= 0.
//  - Latency (start seen in cycle 0): non-MUL -> valid in cycle 1. MUL -> busy in cycles 1..ITERS, valid in cycle ITERS+1 with busy=0.
//  - Back-to-back: start may be high in the same cycle valid is high; it is accepted (state is IDLE).
//  - start while busy=1: ignored, no queueing; operands latched at accept are unaffected.
//  - Mid-MUL changes on operand_a, operand_b or alu_control have no effect.
//  - Arithmetic (all modulo 2^DATA_W):
//    ADD/SUB wrap around.
//    SLL/SRL shift amount = operand_b[log2(DATA_W)-1:0]; SRL is logical.
//    SLT is a signed compare; result = {0..0, a<b}.
//    MUL returns the low DATA_W bits of the product; signed and unsigned give identical low bits.
//  - Unassigned codes (5, 9..15): result <= 0 with valid pulse, single cycle.
//  - zero always reflects the registered result, including after reset.
// STRUCTURE
//  - Shared package alu_pkg: ALU op code localparams (AND..MUL), also used by alu_control; FSM state encoding.
//  - Sub-module mul_iter: shift-add datapath with acc, multiplicand, multiplier and cnt;
//    ports load/step/done; the top-level FSM sequences it.
//  - Single-cycle ops are combinational, muxed into the result register in the top level.
// TESTING
//  1 Reset: hold arst_n=0 for 2 cycles -> result=0, zero=1, busy=0, valid=0.
//  2 ADD a=5, b=-7 (DATA_W=64) -> cycle 1: valid=1, result=0xFFFF_FFFF_FFFF_FFFE, zero=0.
//    SUB a=b=9 -> result=0, zero=1.
//  3 MUL a=0x1_0000_0001, b=3, MUL_STEP=1 -> busy cycles 1..64, valid at cycle 65, result=0x3_0000_0003.
//    Also a=-2, b=3 -> result=-6.
//  4 start with ADD while busy (mid-MUL) -> ignored; MUL result unchanged; no extra valid pulse.
//  5 arst_n=0 at MUL cycle 20 -> next cycle busy=0, valid=0, result=0.
//    A new SLT a=-1, b=1 then gives result=1.
//  6 Back-to-back: SLL a=1, b=0x43 (amt 3) then SRL a=0x80, b=7 on consecutive starts
//    -> valid both cycles 1 and 2; results 8, then 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes (also used by the ALU control decoder), FSM state encoding,
// and a helper that gives the MUL iteration count.
// Latency: n/a. Backpressure: n/a.
package alu_pkg;

  // ALU control codes
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_SRL = 4'd4;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;

  // Execute-stage sequencer states
  typedef enum logic {
    S_IDLE    = 1'b0,
    S_MUL_RUN = 1'b1
  } state_t;

  // Number of shift-add cycles a MUL takes
  function automatic int mul_iters(input int data_w, input int mul_step);
    return data_w / mul_step;
  endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// EX-stage request/response bundle between the pipeline controller (master) and the ALU (slave).
// Ports: start/alu_control/operand_a/operand_b toward the ALU; result/zero/busy/valid back.
// Latency/backpressure: none in the bundle itself; the slave stalls requests via busy.
interface alu_seq_exec_if #(
  parameter int DATA_W = 64
);
  logic              start;
  logic [3:0]        alu_control;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              busy;
  logic              valid;

  modport master (
    output start, alu_control, operand_a, operand_b,
    input  result, zero, busy, valid
  );

  modport slave (
    input  start, alu_control, operand_a, operand_b,
    output result, zero, busy, valid
  );
endinterface

// File: rtl/alu_seq_exec_mul_iter.sv
// Iterative shift-add multiplier datapath retiring MUL_STEP multiplier bits per step.
// Latency: ITERS steps after load; o_product shows the value acc will hold after this step.
// Backpressure: none; the caller asserts i_step only while a MUL is running.
// Ports: clk, arst_n (sync, active-low), i_load/i_a/i_b latch operands, i_step advances,
//        o_done is high on the final step, o_product is the low DATA_W bits including this step.
module mul_iter
  import alu_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int MUL_STEP = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_product,
  output logic              o_done
);
  localparam int ITERS = mul_iters(DATA_W, MUL_STEP);
  localparam int CNT_W = $clog2(ITERS + 1);

  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [CNT_W-1:0]  r_cnt;

  logic [DATA_W-1:0] w_mlsb;
  logic [DATA_W-1:0] w_partial;
  logic [DATA_W-1:0] w_acc_next;

  // Only the low MUL_STEP multiplier bits take part in this step's partial product
  always_comb begin
    w_mlsb                 = '0;
    w_mlsb[MUL_STEP-1:0]   = r_mplier[MUL_STEP-1:0];
  end

  // Product truncated to DATA_W: low bits are identical for signed and unsigned operands
  assign w_partial  = r_mcand * w_mlsb;
  assign w_acc_next = r_acc + w_partial;
  assign o_product  = w_acc_next;
  assign o_done     = (r_cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
    end else if (i_load) begin
      r_acc    <= '0;
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_cnt    <= CNT_W'(ITERS);
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << MUL_STEP;
      r_mplier <= r_mplier >> MUL_STEP;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB/SLL/SRL/SLT, iterative shift-add MUL.
// Latency: 1 cycle for single-cycle ops; DATA_W/MUL_STEP+1 cycles for MUL (busy meanwhile).
// Backpressure: start is ignored while busy; nothing is queued.
// Ports: clk, arst_n (sync, active-low), bus (slave side of alu_seq_exec_if).
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int MUL_STEP = 1
) (
  input  logic          clk,
  input  logic          arst_n,
  alu_seq_exec_if.slave bus
);
  localparam int SH_W = $clog2(DATA_W);

  state_t            r_state;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic              r_busy;
  logic              r_valid;

  logic [DATA_W-1:0] w_alu;
  logic [SH_W-1:0]   w_shamt;
  logic              w_accept;
  logic              w_mul_load;
  logic              w_mul_step;
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_product;

  assign w_shamt    = bus.operand_b[SH_W-1:0];
  assign w_accept   = (r_state == S_IDLE) && bus.start;
  assign w_mul_load = w_accept && (bus.alu_control == ALU_MUL);
  assign w_mul_step = (r_state == S_MUL_RUN);

  // Single-cycle ops; unassigned codes produce 0
  always_comb begin
    w_alu = '0;
    case (bus.alu_control)
      ALU_AND: w_alu = bus.operand_a & bus.operand_b;
      ALU_OR:  w_alu = bus.operand_a | bus.operand_b;
      ALU_ADD: w_alu = bus.operand_a + bus.operand_b;
      ALU_SUB: w_alu = bus.operand_a - bus.operand_b;
      ALU_SLL: w_alu = bus.operand_a << w_shamt;
      ALU_SRL: w_alu = bus.operand_a >> w_shamt;
      ALU_SLT: w_alu[0] = ($signed(bus.operand_a) < $signed(bus.operand_b));
      default: w_alu = '0;
    endcase
  end

  mul_iter #(
    .DATA_W   (DATA_W),
    .MUL_STEP (MUL_STEP)
  ) u_mul_iter (
    .clk       (clk),
    .arst_n    (arst_n),
    .i_load    (w_mul_load),
    .i_step    (w_mul_step),
    .i_a       (bus.operand_a),
    .i_b       (bus.operand_b),
    .o_product (w_mul_product),
    .o_done    (w_mul_done)
  );

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mul_load) begin
            r_state <= S_MUL_RUN;
            r_busy  <= 1'b1;
          end else if (w_accept) begin
            r_result <= w_alu;
            r_zero   <= (w_alu == '0);
            r_valid  <= 1'b1;
          end
        end
        S_MUL_RUN: begin
          // Final step: the product already includes this cycle's partial product
          if (w_mul_done) begin
            r_result <= w_mul_product;
            r_zero   <= (w_mul_product == '0);
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result = r_result;
  assign bus.zero   = r_zero;
  assign bus.busy   = r_busy;
  assign bus.valid  = r_valid;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec with a result scoreboard (DATA_W=64, MUL_STEP=1).
// Latency: checks 1-cycle ops and 65-cycle MUL timing.
// Backpressure: drives start while busy and expects it to be dropped.
module tb_alu_seq_exec;
  localparam int DW    = 64;
  localparam int ITERS = 64;

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  logic clk;
  logic arst_n;

  alu_seq_exec_if #(.DATA_W(DW)) bus ();

  alu_seq_exec #(
    .DATA_W   (DW),
    .MUL_STEP (1)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Reference behaviour of every op code
  function automatic logic [DW-1:0] model(input logic [3:0] op, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [DW-1:0] r;
    r = '0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_ADD: r = a + b;
      OP_SUB: r = a - b;
      OP_SLL: r = a << b[5:0];
      OP_SRL: r = a >> b[5:0];
      OP_SLT: r = {63'd0, ($signed(a) < $signed(b))};
      OP_MUL: r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Scoreboard: every valid pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (arst_n && bus.valid === 1'b1) begin
      chk("sb_expected_pending", DW'(exp_q.size() != 0), DW'(1));
      if (exp_q.size() != 0) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        chk("sb_result", bus.result, e);
        chk("sb_zero", DW'(bus.zero), DW'(e == '0));
      end
    end
  end

  // Drive a request at the current negedge and record its expected result
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] expv);
    bus.start       = 1'b1;
    bus.alu_control = op;
    bus.operand_a   = a;
    bus.operand_b   = b;
    exp_q.push_back(expv);
  endtask

  task automatic run_single(input string tag, input logic [3:0] op, input logic [DW-1:0] a,
                            input logic [DW-1:0] b, input logic [DW-1:0] expv);
    issue(op, a, b, expv);
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_valid"}, DW'(bus.valid), DW'(1));
    chk({tag, "_busy"}, DW'(bus.busy), DW'(0));
    @(negedge clk);
    chk({tag, "_pulse"}, DW'(bus.valid), DW'(0));
  endtask

  initial begin
    int busy_ok;
    int lat;
    logic [3:0] rops [10];
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;

    rops = '{OP_AND, OP_OR, OP_ADD, OP_SLL, OP_SRL, OP_SUB, OP_SLT, 4'd5, 4'd9, 4'd15};

    bus.start       = 1'b0;
    bus.alu_control = '0;
    bus.operand_a   = '0;
    bus.operand_b   = '0;
    arst_n          = 1'b0;

    // Reset held for two cycles
    @(negedge clk);
    @(negedge clk);
    chk("rst_result", bus.result, '0);
    chk("rst_zero", DW'(bus.zero), DW'(1));
    chk("rst_busy", DW'(bus.busy), DW'(0));
    chk("rst_valid", DW'(bus.valid), DW'(0));
    arst_n = 1'b1;
    @(negedge clk);

    // Wrapping ADD and zero-producing SUB
    run_single("add", OP_ADD, 64'd5, -64'sd7, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("add_zero_flag", DW'(bus.zero), DW'(0));
    run_single("sub", OP_SUB, 64'd9, 64'd9, 64'd0);
    chk("sub_zero_flag", DW'(bus.zero), DW'(1));

    // MUL with a start (ADD) attempted mid-run and operands disturbed afterwards
    issue(OP_MUL, 64'h1_0000_0001, 64'd3, 64'h3_0000_0003);
    @(negedge clk);
    busy_ok = 0;
    for (int k = 1; k <= ITERS; k++) begin
      if (bus.busy === 1'b1 && bus.valid === 1'b0) busy_ok++;
      if (k == 1) bus.start = 1'b0;
      if (k == 20) begin
        bus.start       = 1'b1;
        bus.alu_control = OP_ADD;
        bus.operand_a   = 64'd1;
        bus.operand_b   = 64'd1;
      end
      if (k == 21) begin
        bus.start     = 1'b0;
        bus.operand_a = {$urandom, $urandom};
        bus.operand_b = {$urandom, $urandom};
      end
      @(negedge clk);
    end
    chk("mul_busy_cycles", DW'(busy_ok), DW'(ITERS));
    chk("mul_valid_at_65", DW'(bus.valid), DW'(1));
    chk("mul_busy_low_at_65", DW'(bus.busy), DW'(0));
    @(negedge clk);
    chk("mul_no_extra_valid", DW'(bus.valid), DW'(0));

    // Negative MUL with a bounded wait for completion
    issue(OP_MUL, -64'sd2, 64'd3, -64'sd6);
    lat = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end while (bus.valid !== 1'b1 && lat < 200);
    chk("mul_neg_latency", DW'(lat), DW'(ITERS + 1));
    @(negedge clk);

    // Reset in MUL cycle 20 discards the operation
    issue(OP_MUL, 64'd7, 64'd9, 64'd63);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k < 20; k++) @(negedge clk);
    arst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    chk("midrst_busy", DW'(bus.busy), DW'(0));
    chk("midrst_valid", DW'(bus.valid), DW'(0));
    chk("midrst_result", bus.result, '0);
    arst_n = 1'b1;
    @(negedge clk);
    run_single("slt", OP_SLT, -64'sd1, 64'd1, 64'd1);

    // Back-to-back SLL then SRL
    issue(OP_SLL, 64'd1, 64'h43, 64'd8);
    @(negedge clk);
    chk("b2b_valid1", DW'(bus.valid), DW'(1));
    issue(OP_SRL, 64'h80, 64'd7, 64'd1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_valid2", DW'(bus.valid), DW'(1));
    @(negedge clk);
    chk("b2b_pulse", DW'(bus.valid), DW'(0));

    // Unassigned codes and a random sweep of single-cycle ops
    run_single("code5", 4'd5, 64'd12, 64'd34, 64'd0);
    run_single("code12", 4'd12, 64'hFF, 64'h1, 64'd0);
    for (int i = 0; i < 10; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      run_single("rand", rops[i], ra, rb, model(rops[i], ra, rb));
    end

    // Random MUL against the product model
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    issue(OP_MUL, ra, rb, model(OP_MUL, ra, rb));
    lat = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end while (bus.valid !== 1'b1 && lat < 200);
    chk("mul_rand_latency", DW'(lat), DW'(ITERS + 1));

    @(negedge clk);
    @(negedge clk);
    chk("sb_drained", DW'(exp_q.size()), DW'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
